vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised VGA timing generator and pixel output stage, successor to the fixed 640x480 vga block. Derives the pixel clock from CLK with a divider, generates HS/VS/blank from generic porch/sync parameters, and exposes pixel coordinates to an upstream renderer. Registers the renderer's colour onto the DAC pins aligned with sync. Sits between the frame renderer and the board VGA DAC.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 2, CLK cycles per pixel; even, >=2
HS_POL, 0, asserted level of VGA_HS_O
VS_POL, 0, asserted level of VGA_VS_O
COLOR_W, 8, bits per colour channel

Ports:
CLK  in  1  system clock (50 MHz nominal)
RST_N  in  1  asynchronous reset, active-low
PIX_R  in  COLOR_W  renderer red for pixel (X,Y)
PIX_G  in  COLOR_W  renderer green
PIX_B  in  COLOR_W  renderer blue
TP_SEL  in  1  test-pattern select (used only with TEST_PATTERN_EN)
X  out  clog2(H_TOTAL)  current horizontal count
Y  out  clog2(V_TOTAL)  current vertical count
ACTIVE  out  1  (X,Y) inside visible area
FRAME_START  out  1  one-CLK pulse at start of frame
VGA_CLK  out  1  pixel clock to DAC
VGA_HS_O  out  1  horizontal sync
VGA_VS_O  out  1  vertical sync
VGA_BLANK_N  out  1  low during blanking
VGA_R  out  COLOR_W  red to DAC
VGA_G  out  COLOR_W  green to DAC
VGA_B  out  COLOR_W  blue to DAC

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- Divider counts 0..CLK_DIV-1; pixel tick when div==CLK_DIV-1. VGA_CLK registered: 0 for div<CLK_DIV/2, 1 otherwise; its rising edge is mid-pixel.
- h_cnt advances on tick, wraps H_TOTAL-1 -> 0; v_cnt advances when h_cnt wraps, wraps V_TOTAL-1 -> 0. Both wrap on the same tick at (H_TOTAL-1, V_TOTAL-1).
- X=h_cnt, Y=v_cnt, ACTIVE=(h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE): registered, change only on tick.
- FRAME_START: high for exactly one CLK, on the CLK after the tick that sets (0,0).
- Pipeline, 1-pixel latency: on each tick, register PIX_* (or 0 when !ACTIVE), BLANK_N=ACTIVE, and sync for the current (X,Y). DAC outputs therefore lag X/Y by one pixel. Renderer must present PIX_* combinationally from X/Y within one pixel period.
- HS asserted (=HS_POL) for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], else ~HS_POL. VS asserted (=VS_POL) for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], whole lines.
- Reset (async assert, applied on CLK edge at deassert): div, h_cnt, v_cnt, X, Y=0; ACTIVE=0; FRAME_START=0; VGA_CLK=0; HS=~HS_POL; VS=~VS_POL; BLANK_N=0; RGB=0. After release, first tick sets ACTIVE=1 at (0,0) and pulses FRAME_START.
- Reset mid-frame: all state returns to reset values immediately; no partial-line sync is emitted.
- Colour is never driven nonzero while BLANK_N=0.

Optional Feature:
TEST_PATTERN_EN: when defined and TP_SEL=1, PIX_* are ignored and 8 vertical colour bars (width H_ACTIVE/8, order white, yellow, cyan, green, magenta, red, blue, black; full scale = all ones) are driven with the same latency and blanking. When not defined, TP_SEL is unused and PIX_* always pass through.

Test Plan:
- Defaults, release reset, run 2 frames -> FRAME_START period 840000 CLK; VGA_CLK period 2 CLK.
- HS check -> each line VGA_HS_O low for 192 CLK, falling one pixel after X reaches 656; 800 pixels per line.
- VS check -> VGA_VS_O low for 2 lines (1600 pixels) from one pixel after Y reaches 490; 525 lines per frame.
- PIX_R=X[7:0], PIX_G=Y[7:0] -> VGA_R one pixel later equals previous X; RGB=0 and BLANK_N=0 for X>=640 or Y>=480.
- Assert RST_N low at X=300,Y=200 for 3 CLK -> all outputs immediately at reset values; after release FRAME_START within 2 CLK.
- TEST_PATTERN_EN, TP_SEL=1 -> X=0..79 RGB=FF/FF/FF, X=80..159 FF/FF/00, X=560..639 00/00/00.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA timing generator and pixel output stage. A divider turns
//   CLK into pixel ticks. Horizontal and vertical counters produce the pixel
//   coordinates, and a one-pixel pipeline registers colour, blank and sync
//   onto the DAC pins.
//
//   Optional build macro: TEST_PATTERN_EN. When it is defined and TP_SEL=1,
//   eight full-scale vertical colour bars replace the renderer's colour.
//
// Ports
//   CLK, RST_N          system clock, asynchronous active-low reset
//   PIX_R/G/B           renderer colour for the current (X,Y); must be valid
//                       combinationally within one pixel period
//   TP_SEL              test-pattern select (TEST_PATTERN_EN builds only)
//   X, Y, ACTIVE        current coordinates and visible-area flag
//   FRAME_START         one-CLK pulse after the tick that enters (0,0)
//   VGA_CLK             pixel clock; its rising edge falls mid-pixel
//   VGA_HS_O, VGA_VS_O  syncs, lagging X/Y by one pixel
//   VGA_BLANK_N         low during blanking, lagging X/Y by one pixel
//   VGA_R/G/B           colour to the DAC, lagging X/Y by one pixel
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int COLOR_W  = 8
) (
  input  logic                                              CLK,
  input  logic                                              RST_N,
  input  logic [COLOR_W-1:0]                                PIX_R,
  input  logic [COLOR_W-1:0]                                PIX_G,
  input  logic [COLOR_W-1:0]                                PIX_B,
  input  logic                                              TP_SEL,
  output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]      X,
  output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]      Y,
  output logic                                              ACTIVE,
  output logic                                              FRAME_START,
  output logic                                              VGA_CLK,
  output logic                                              VGA_HS_O,
  output logic                                              VGA_VS_O,
  output logic                                              VGA_BLANK_N,
  output logic [COLOR_W-1:0]                                VGA_R,
  output logic [COLOR_W-1:0]                                VGA_G,
  output logic [COLOR_W-1:0]                                VGA_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [XW-1:0]    H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0]    H_ACT    = XW'(H_ACTIVE);
  localparam logic [XW-1:0]    HS_START = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0]    HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [YW-1:0]    V_LAST   = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0]    V_ACT    = YW'(V_ACTIVE);
  localparam logic [YW-1:0]    VS_START = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0]    VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic             HS_ON    = (HS_POL != 0);
  localparam logic             VS_ON    = (VS_POL != 0);

  logic [DIV_W-1:0]   div_q, div_d;
  logic               run_q, run_d;
  logic [XW-1:0]      h_cnt_q, h_cnt_d;
  logic [YW-1:0]      v_cnt_q, v_cnt_d;
  logic               active_q, active_d;
  logic               frame_start_q, frame_start_d;
  logic               vga_clk_q, vga_clk_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic               blank_n_q, blank_n_d;
  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

  logic               tick;
  logic [XW-1:0]      h_nxt;
  logic [YW-1:0]      v_nxt;
  logic [COLOR_W-1:0] src_r, src_g, src_b;

  // Colour source for the current pixel.
`ifdef TEST_PATTERN_EN
  logic [2:0] bar;
  logic [2:0] bar_rgb;

  always_comb begin
    bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (h_cnt_q >= XW'(i * (H_ACTIVE / 8))) bar = 3'(i);
    end
    // {R,G,B} enables: white, yellow, cyan, green, magenta, red, blue, black
    case (bar)
      3'd0:    bar_rgb = 3'b111;
      3'd1:    bar_rgb = 3'b110;
      3'd2:    bar_rgb = 3'b011;
      3'd3:    bar_rgb = 3'b010;
      3'd4:    bar_rgb = 3'b101;
      3'd5:    bar_rgb = 3'b100;
      3'd6:    bar_rgb = 3'b001;
      default: bar_rgb = 3'b000;
    endcase
    src_r = TP_SEL ? {COLOR_W{bar_rgb[2]}} : PIX_R;
    src_g = TP_SEL ? {COLOR_W{bar_rgb[1]}} : PIX_G;
    src_b = TP_SEL ? {COLOR_W{bar_rgb[0]}} : PIX_B;
  end
`else
  logic unused_tp;
  assign unused_tp = TP_SEL;

  always_comb begin
    src_r = PIX_R;
    src_g = PIX_G;
    src_b = PIX_B;
  end
`endif

  always_comb begin
    div_d         = div_q;
    run_d         = run_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    active_d      = active_q;
    frame_start_d = 1'b0;
    hs_d          = hs_q;
    vs_d          = vs_q;
    blank_n_d     = blank_n_q;
    r_d           = r_q;
    g_d           = g_q;
    b_d           = b_q;

    tick      = (div_q == DIV_LAST);
    div_d     = tick ? '0 : div_q + DIV_W'(1);
    // Derived from the next divider value so VGA_CLK tracks div_q exactly.
    vga_clk_d = (div_d >= DIV_HALF);

    // After reset the counters already sit at (0,0); the first tick only
    // makes that pixel visible instead of advancing past it.
    h_nxt = h_cnt_q;
    v_nxt = v_cnt_q;
    if (!run_q) begin
      h_nxt = '0;
      v_nxt = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + YW'(1);
    end else begin
      h_nxt = h_cnt_q + XW'(1);
    end

    if (tick) begin
      run_d         = 1'b1;
      h_cnt_d       = h_nxt;
      v_cnt_d       = v_nxt;
      active_d      = (h_nxt < H_ACT) && (v_nxt < V_ACT);
      frame_start_d = (h_nxt == '0) && (v_nxt == '0);
      // Output stage describes the pixel being left, hence one pixel of lag.
      hs_d          = (h_cnt_q >= HS_START && h_cnt_q <= HS_END) ? HS_ON : ~HS_ON;
      vs_d          = (v_cnt_q >= VS_START && v_cnt_q <= VS_END) ? VS_ON : ~VS_ON;
      blank_n_d     = active_q;
      r_d           = active_q ? src_r : '0;
      g_d           = active_q ? src_g : '0;
      b_d           = active_q ? src_b : '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_q         <= '0;
      run_q         <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
      vga_clk_q     <= 1'b0;
      hs_q          <= ~HS_ON;
      vs_q          <= ~VS_ON;
      blank_n_q     <= 1'b0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
    end else begin
      div_q         <= div_d;
      run_q         <= run_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
      vga_clk_q     <= vga_clk_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
    end
  end

  assign X           = h_cnt_q;
  assign Y           = v_cnt_q;
  assign ACTIVE      = active_q;
  assign FRAME_START = frame_start_q;
  assign VGA_CLK     = vga_clk_q;
  assign VGA_HS_O    = hs_q;
  assign VGA_VS_O    = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Bench for vga_timing_gen with a shrunken raster:
//   H = 16 active + 4 FP + 6 sync + 6 BP = 32 pixels per line,
//   V = 8 active + 2 FP + 2 sync + 3 BP = 15 lines per frame,
//   CLK_DIV = 4, HS active-low, VS active-high.
//   The renderer returns R = X, G = Y, B = 8'hA5.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int H_ACTIVE = 16, H_FP = 4, H_SYNC = 6, H_BP = 6;
  localparam int V_ACTIVE = 8,  V_FP = 2, V_SYNC = 2, V_BP = 3;
  localparam int CLK_DIV  = 4,  HS_POL = 0, VS_POL = 1, COLOR_W = 8;
  localparam int FRAME_CLKS   = 1920; // 32 * 15 * 4
  localparam int HS_LOW_CLKS  = 24;   // 6 pixels * 4
  localparam int VS_HIGH_CLKS = 256;  // 2 lines * 32 * 4
  localparam int EXP_W        = 36;   // x(5) y(4) r g b(24) bn hs vs(3)

  logic       clk, rst_n, tp_sel;
  logic [7:0] pix_r, pix_g, pix_b;
  logic [4:0] x;
  logic [3:0] y;
  logic       active, frame_start, vga_clk, hs, vs, blank_n;
  logic [7:0] r, g, b;

  logic [EXP_W-1:0] exp_q[$];
  string            name_q[$];
  int n_vec = 0;
  int n_err = 0;
  int blank_viol = 0;

  assign pix_r = {3'b000, x};
  assign pix_g = {4'b0000, y};
  assign pix_b = 8'hA5;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CLK_DIV(CLK_DIV), .HS_POL(HS_POL), .VS_POL(VS_POL), .COLOR_W(COLOR_W)
  ) dut (
    .CLK(clk), .RST_N(rst_n),
    .PIX_R(pix_r), .PIX_G(pix_g), .PIX_B(pix_b), .TP_SEL(tp_sel),
    .X(x), .Y(y), .ACTIVE(active), .FRAME_START(frame_start),
    .VGA_CLK(vga_clk), .VGA_HS_O(hs), .VGA_VS_O(vs), .VGA_BLANK_N(blank_n),
    .VGA_R(r), .VGA_G(g), .VGA_B(b)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, need %0d", nm, act, expv);
    end
  endtask

  // Expected DAC state while (px,py) is on X/Y, i.e. the output for the pixel before it.
  task automatic push(input string nm, input int px, input int py,
                      input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb,
                      input logic ebn, input logic ehs, input logic evs);
    exp_q.push_back({5'(px), 4'(py), er, eg, eb, ebn, ehs, evs});
    name_q.push_back(nm);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("sb_drain_left", exp_q.size(), 0);
    exp_q.delete();
    name_q.delete();
  endtask

  // Counts CLK edges from the current point until FRAME_START is seen.
  task automatic fs_latency(input string nm, input int expv);
    int lat;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (frame_start) break;
    end
    chk(nm, lat, expv);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_x"}, x, 0);
    chk({tag, "_y"}, y, 0);
    chk({tag, "_active"}, active, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
    chk({tag, "_vga_clk"}, vga_clk, 0);
    chk({tag, "_hs"}, hs, 1);
    chk({tag, "_vs"}, vs, 0);
    chk({tag, "_blank_n"}, blank_n, 0);
    chk({tag, "_rgb"}, {r, g, b}, 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EXP_W-1:0] e;
    logic [26:0]      act;
    string            nm;
    int ncyc, vclk_rise, hs_fall, vs_rise, fs_last;
    logic p_vclk, p_hs, p_vs, p_fs;
    ncyc = 0; vclk_rise = -1; hs_fall = -1; vs_rise = -1; fs_last = -1;
    p_vclk = 1'b0; p_hs = 1'b1; p_vs = 1'b0; p_fs = 1'b0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!rst_n) begin
        vclk_rise = -1; hs_fall = -1; vs_rise = -1; fs_last = -1;
        p_vclk = 1'b0; p_hs = 1'b1; p_vs = 1'b0; p_fs = 1'b0;
      end else begin
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          if (x == e[35:31] && y == e[30:27]) begin
            void'(exp_q.pop_front());
            nm  = name_q.pop_front();
            act = {r, g, b, blank_n, hs, vs};
            n_vec++;
            if (act !== e[26:0]) begin
              n_err++;
              $display("FAIL %s at x=%0d y=%0d: got rgb=%h/%h/%h bn=%b hs=%b vs=%b, need rgb=%h/%h/%h bn=%b hs=%b vs=%b",
                       nm, x, y, r, g, b, blank_n, hs, vs,
                       e[26:19], e[18:11], e[10:3], e[2], e[1], e[0]);
            end
          end
        end
        if (!blank_n && ({r, g, b} != 24'h0)) blank_viol++;
        if (vga_clk && !p_vclk) begin
          if (vclk_rise >= 0) chk("vga_clk_period", ncyc - vclk_rise, CLK_DIV);
          vclk_rise = ncyc;
        end
        if (!vga_clk && p_vclk && vclk_rise >= 0) chk("vga_clk_high", ncyc - vclk_rise, CLK_DIV / 2);
        if (!hs && p_hs) hs_fall = ncyc;
        if (hs && !p_hs && hs_fall >= 0) chk("hs_low_width", ncyc - hs_fall, HS_LOW_CLKS);
        if (vs && !p_vs) vs_rise = ncyc;
        if (!vs && p_vs && vs_rise >= 0) chk("vs_high_width", ncyc - vs_rise, VS_HIGH_CLKS);
        if (frame_start && !p_fs) begin
          if (fs_last >= 0) chk("frame_period", ncyc - fs_last, FRAME_CLKS);
          fs_last = ncyc;
        end
        if (!frame_start && p_fs) chk("frame_start_width", ncyc - fs_last, 1);
        p_vclk = vga_clk; p_hs = hs; p_vs = vs; p_fs = frame_start;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int found;
    rst_n  = 1'b0;
    tp_sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("rst");

    // Frame 1: pixel path, HS and VS edges (values hand-derived).
    push("act_x1y0",   1,  0, 8'h00, 8'h00, 8'hA5, 1, 1, 0);
    push("act_x9y1",   9,  1, 8'h08, 8'h01, 8'hA5, 1, 1, 0);
    push("last_act",  16,  1, 8'h0F, 8'h01, 8'hA5, 1, 1, 0);
    push("first_fp",  17,  1, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    push("hs_pre",    20,  1, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    push("hs_first",  21,  1, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    push("hs_last",   26,  1, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    push("hs_after",  27,  1, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    push("line_wrap",  0,  2, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    push("line_start", 1,  2, 8'h00, 8'h02, 8'hA5, 1, 1, 0);
    push("last_line", 16,  7, 8'h0F, 8'h07, 8'hA5, 1, 1, 0);
    push("first_vfp",  1,  8, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    push("v_blank",    5,  8, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    push("vs_pre",     0, 10, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    push("vs_first",   1, 10, 8'h00, 8'h00, 8'h00, 0, 1, 1);
    push("vs_hs",     21, 10, 8'h00, 8'h00, 8'h00, 0, 0, 1);
    push("vs_last",    0, 12, 8'h00, 8'h00, 8'h00, 0, 1, 1);
    push("vs_after",   1, 12, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    push("frame_end", 31, 14, 8'h00, 8'h00, 8'h00, 0, 1, 0);

    rst_n = 1'b1;
    fs_latency("fs_latency_boot", CLK_DIV);
    chk("boot_x", x, 0);
    chk("boot_y", y, 0);
    chk("boot_active", active, 1);
    drain(3000);

    // Frame 2: TP_SEL raised at frame start.
    found = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (frame_start) begin found = 1; break; end
    end
    chk("wait_frame2", found, 1);
    tp_sel = 1'b1;
`ifdef TEST_PATTERN_EN
    push("tp_white",    1, 2, 8'hFF, 8'hFF, 8'hFF, 1, 1, 0);
    push("tp_yellow",   3, 2, 8'hFF, 8'hFF, 8'h00, 1, 1, 0);
    push("tp_cyan",     5, 2, 8'h00, 8'hFF, 8'hFF, 1, 1, 0);
    push("tp_green",    7, 2, 8'h00, 8'hFF, 8'h00, 1, 1, 0);
    push("tp_magenta",  9, 2, 8'hFF, 8'h00, 8'hFF, 1, 1, 0);
    push("tp_red",     11, 2, 8'hFF, 8'h00, 8'h00, 1, 1, 0);
    push("tp_blue",    13, 2, 8'h00, 8'h00, 8'hFF, 1, 1, 0);
    push("tp_black",   15, 2, 8'h00, 8'h00, 8'h00, 1, 1, 0);
    push("tp_black_e", 16, 2, 8'h00, 8'h00, 8'h00, 1, 1, 0);
    push("tp_blank",   17, 2, 8'h00, 8'h00, 8'h00, 0, 1, 0);
`else
    push("tp_pass_1",   1, 2, 8'h00, 8'h02, 8'hA5, 1, 1, 0);
    push("tp_pass_3",   3, 2, 8'h02, 8'h02, 8'hA5, 1, 1, 0);
    push("tp_pass_5",   5, 2, 8'h04, 8'h02, 8'hA5, 1, 1, 0);
    push("tp_pass_7",   7, 2, 8'h06, 8'h02, 8'hA5, 1, 1, 0);
    push("tp_pass_9",   9, 2, 8'h08, 8'h02, 8'hA5, 1, 1, 0);
    push("tp_pass_11", 11, 2, 8'h0A, 8'h02, 8'hA5, 1, 1, 0);
    push("tp_pass_13", 13, 2, 8'h0C, 8'h02, 8'hA5, 1, 1, 0);
    push("tp_pass_15", 15, 2, 8'h0E, 8'h02, 8'hA5, 1, 1, 0);
    push("tp_pass_16", 16, 2, 8'h0F, 8'h02, 8'hA5, 1, 1, 0);
    push("tp_blank",   17, 2, 8'h00, 8'h00, 8'h00, 0, 1, 0);
`endif
    drain(3000);
    tp_sel = 1'b0;

    // Mid-frame reset inside the visible area.
    found = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (x == 5'd10 && y == 4'd3) begin found = 1; break; end
    end
    chk("wait_x10y3", found, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset("midrst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("midrst_hold");
    push("post_rst_x1y0", 1, 0, 8'h00, 8'h00, 8'hA5, 1, 1, 0);
    push("post_rst_x9y1", 9, 1, 8'h08, 8'h01, 8'hA5, 1, 1, 0);
    rst_n = 1'b1;
    fs_latency("fs_latency_midrst", CLK_DIV);
    drain(3000);

    chk("blank_rgb_zero", blank_viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
